// File: rtl/spy_sensor_pkg.sv
// Shared types and helpers for the spy delay-line timing sensor.
package spy_sensor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StLaunch,
    StCapture,
    StEncode,
    StDone
  } state_e;

  // Width needed to hold a tap count of 0..ntaps inclusive.
  function automatic int unsigned code_width(input int unsigned ntaps);
    return $clog2(ntaps + 1);
  endfunction

endpackage

// File: rtl/spy_delay_chain.sv
// Chain of inverting spy cells with a tap every TAP_STRIDE cells; purely combinational.
module spy_delay_chain #(
  parameter int unsigned STAGES     = 100,
  parameter int unsigned TAP_STRIDE = 4,
  localparam int unsigned NTAPS     = STAGES / TAP_STRIDE
) (
  input  logic             launch,
  output logic [NTAPS-1:0] taps
);

  // Each cell lives in its own scope so the tool sees distinct nets, not one self-feeding vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_cell
    (* keep *) logic cell_out;
    if (k == 0) begin : g_first
      assign cell_out = ~launch;
    end else begin : g_next
      assign cell_out = ~g_cell[k-1].cell_out;
    end
  end

  for (genvar i = 0; i < NTAPS; i++) begin : g_tap
    assign taps[i] = g_cell[(i+1)*TAP_STRIDE-1].cell_out;
  end

endmodule

// File: rtl/spy_delay_sensor.sv
// Delay-line timing sensor: launches edges into the spy chain, captures taps, encodes and
// accumulates SAMPLES measurements per request.
module spy_delay_sensor
  import spy_sensor_pkg::*;
#(
  parameter int unsigned STAGES     = 100,
  parameter int unsigned TAP_STRIDE = 4,
  parameter int unsigned SAMPLES    = 16,
  parameter int unsigned SETTLE_CYC = 8,
  localparam int unsigned NTAPS     = STAGES / TAP_STRIDE,
  localparam int unsigned CODE_W    = code_width(NTAPS),
  localparam int unsigned SUM_W     = CODE_W + $clog2(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              meas_valid,
  output logic [CODE_W-1:0] meas_code,
  output logic              bubble_err,
  output logic              done,
  output logic [SUM_W-1:0]  sum_code,
  output logic [CODE_W-1:0] min_code,
  output logic [CODE_W-1:0] max_code
);

  localparam int unsigned SCNT_W = $clog2(SETTLE_CYC);
  localparam int unsigned SMP_W  = $clog2(SAMPLES);

  state_e state_q, state_d;

  logic [SCNT_W-1:0] settle_cnt_q;
  logic [SMP_W-1:0]  sample_cnt_q;
  logic              launch_q;
  logic [NTAPS-1:0]  tap_q;
  logic              meas_valid_q;
  logic [CODE_W-1:0] meas_code_q;
  logic              bubble_q;
  logic [SUM_W-1:0]  sum_q;
  logic [CODE_W-1:0] min_acc_q;
  logic [CODE_W-1:0] min_code_q;
  logic [CODE_W-1:0] max_code_q;

  (* keep *) logic [NTAPS-1:0] taps;

  logic              settle_last;
  logic              sample_last;
  logic              start_accept;
  logic [NTAPS-1:0]  arrived;
  logic [CODE_W-1:0] enc_code;
  logic              enc_bubble;
  logic              found;
  logic [CODE_W-1:0] new_min;

  spy_delay_chain #(
    .STAGES     (STAGES),
    .TAP_STRIDE (TAP_STRIDE)
  ) u_chain (
    .launch (launch_q),
    .taps   (taps)
  );

  assign settle_last  = (settle_cnt_q == SCNT_W'(SETTLE_CYC - 1));
  assign sample_last  = (sample_cnt_q == SMP_W'(SAMPLES - 1));
  assign start_accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StSettle;
      StSettle:       if (settle_last) state_d = StLaunch;
      StLaunch:       state_d = StCapture;
      StCapture:      state_d = StEncode;
      StEncode:       state_d = sample_last ? StDone : StSettle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StSettle) || (state_q == StLaunch) ||
           (state_q == StCapture) || (state_q == StEncode);
    done = (state_q == StDone);
  end

  // A tap has arrived when it matches the new launch level after its inversion parity.
  always_comb begin
    arrived    = '0;
    enc_code   = CODE_W'(NTAPS);
    enc_bubble = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      arrived[i] = tap_q[i] ^ launch_q ^ 1'(((i + 1) * TAP_STRIDE) % 2) ^ 1'b1;
      if (!found && !arrived[i]) begin
        enc_code = CODE_W'(i);
        found    = 1'b1;
      end else if (found && arrived[i]) begin
        enc_bubble = 1'b1;
      end
    end
  end

  assign new_min = (enc_code < min_acc_q) ? enc_code : min_acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      launch_q     <= 1'b0;
      tap_q        <= '0;
      meas_valid_q <= 1'b0;
      meas_code_q  <= '0;
      bubble_q     <= 1'b0;
      sum_q        <= '0;
      min_acc_q    <= CODE_W'(NTAPS);
      min_code_q   <= '0;
      max_code_q   <= '0;
    end else begin
      meas_valid_q <= 1'b0;
      if (start_accept) begin
        settle_cnt_q <= '0;
        sample_cnt_q <= '0;
        bubble_q     <= 1'b0;
        sum_q        <= '0;
        min_acc_q    <= CODE_W'(NTAPS);
        min_code_q   <= '0;
        max_code_q   <= '0;
      end
      case (state_q)
        StSettle:  settle_cnt_q <= settle_last ? '0 : settle_cnt_q + 1'b1;
        StLaunch:  launch_q <= ~launch_q;
        StCapture: tap_q <= taps;
        StEncode: begin
          meas_valid_q <= 1'b1;
          meas_code_q  <= enc_code;
          bubble_q     <= bubble_q | enc_bubble;
          sum_q        <= sum_q + SUM_W'(enc_code);
          min_acc_q    <= new_min;
          min_code_q   <= new_min;
          if (enc_code > max_code_q) max_code_q <= enc_code;
          sample_cnt_q <= sample_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign meas_valid = meas_valid_q;
  assign meas_code  = meas_code_q;
  assign bubble_err = bubble_q;
  assign sum_code   = sum_q;
  assign min_code   = min_code_q;
  assign max_code   = max_code_q;

endmodule

// File: tb/tb_spy_delay_sensor.sv
// Directed bench for spy_delay_sensor; tap patterns are forced onto the chain output as a stub.
module tb_spy_delay_sensor;

  localparam int unsigned NTAPS = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       meas_valid;
  logic [4:0] meas_code;
  logic       bubble_err;
  logic       done;
  logic [8:0] sum_code;
  logic [4:0] min_code;
  logic [4:0] max_code;

  int errors = 0;
  int checks = 0;
  int n_meas = 0;
  int bad_codes = 0;
  int exp_rise = 25;
  int exp_fall = 25;
  int cycles;
  bit use_stub = 1'b0;
  logic [NTAPS-1:0] arr_rise = '1;
  logic [NTAPS-1:0] arr_fall = '1;

  spy_delay_sensor dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .meas_valid (meas_valid),
    .meas_code  (meas_code),
    .bubble_err (bubble_err),
    .done       (done),
    .sum_code   (sum_code),
    .min_code   (min_code),
    .max_code   (max_code)
  );

  always #5 clk = ~clk;

  // Stride 4 gives even inversion parity on every tap: arrived tap == new launch level.
  always @(negedge clk) begin
    if (use_stub)
      force dut.taps = (dut.launch_q ? arr_rise : arr_fall) ^ {NTAPS{~dut.launch_q}};
  end

  // Even-indexed measurements follow a rising launch, odd ones a falling launch.
  always @(posedge clk) begin
    #2;
    if (meas_valid) begin
      if (32'(meas_code) != ((n_meas % 2 == 0) ? exp_rise : exp_fall)) bad_codes++;
      n_meas++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_run(input int pulse_at, output int cyc);
    n_meas    = 0;
    bad_codes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_code", meas_code, 0);
    check("rst_sum", sum_code, 0);
    check("rst_min", min_code, 0);
    check("rst_max", max_code, 0);
    check("rst_bubble", bubble_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Real zero-delay chain: every tap arrives.
    exp_rise = 25; exp_fall = 25;
    do_run(-1, cycles);
    check("all_cycles", cycles, 176);
    check("all_nmeas", n_meas, 16);
    check("all_codes", bad_codes, 0);
    check("all_sum", sum_code, 400);
    check("all_min", min_code, 25);
    check("all_max", max_code, 25);
    check("all_bubble", bubble_err, 0);
    check("all_busy", busy, 0);

    // No tap arrived; restart from DONE.
    use_stub = 1'b1;
    arr_rise = '0; arr_fall = '0;
    exp_rise = 0;  exp_fall = 0;
    @(negedge clk);
    do_run(-1, cycles);
    check("none_cycles", cycles, 176);
    check("none_codes", bad_codes, 0);
    check("none_sum", sum_code, 0);
    check("none_min", min_code, 0);
    check("none_max", max_code, 0);

    // 10 taps on rising launch, 12 on falling; stray start while busy.
    arr_rise = 25'h00003FF; arr_fall = 25'h0000FFF;
    exp_rise = 10; exp_fall = 12;
    do_run(5, cycles);
    check("alt_cycles", cycles, 176);
    check("alt_nmeas", n_meas, 16);
    check("alt_codes", bad_codes, 0);
    check("alt_sum", sum_code, 176);
    check("alt_min", min_code, 10);
    check("alt_max", max_code, 12);
    check("alt_done", done, 1);

    // Bubble pattern 1101_1: leading count 2, sticky error.
    arr_rise = 25'h000001B; arr_fall = 25'h000001B;
    exp_rise = 2; exp_fall = 2;
    do_run(-1, cycles);
    check("bub_codes", bad_codes, 0);
    check("bub_sum", sum_code, 32);
    check("bub_min", min_code, 2);
    check("bub_max", max_code, 2);
    check("bub_err", bubble_err, 1);
    repeat (4) @(negedge clk);
    check("bub_held", bubble_err, 1);

    // Start from DONE clears sticky error and sums.
    arr_rise = '1; arr_fall = '1;
    exp_rise = 25; exp_fall = 25;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_bubble", bubble_err, 0);
    check("restart_sum", sum_code, 0);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check("restart_cycles", cycles, 176);
    check("restart_sum_end", sum_code, 400);
    check("restart_bub_end", bubble_err, 0);

    // Reset during ENCODE of sample 7 (0-based): cycle 7*11+10 after acceptance.
    arr_rise = 25'h00003FF; arr_fall = 25'h0000FFF;
    exp_rise = 10; exp_fall = 12;
    n_meas = 0; bad_codes = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (cycles < 87) begin
      @(negedge clk);
      cycles++;
    end
    check("mid_nmeas", n_meas, 7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_valid", meas_valid, 0);
    check("mid_code", meas_code, 0);
    check("mid_sum", sum_code, 0);
    check("mid_min", min_code, 0);
    check("mid_max", max_code, 0);
    check("mid_launch", dut.launch_q, 0);
    rst = 1'b0;
    @(negedge clk);
    do_run(-1, cycles);
    check("post_cycles", cycles, 176);
    check("post_codes", bad_codes, 0);
    check("post_sum", sum_code, 176);
    check("post_min", min_code, 10);
    check("post_max", max_code, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
